// File: rtl/fp_i2f_arbiter.sv
// Round-robin front end that shares one pipelined int-to-float converter among
// NREQ requesters, tags each issue with its requester ID and supports draining.
module fp_i2f_arbiter #(
    parameter int NREQ    = 4,
    parameter int EXP     = 8,
    parameter int MANT    = 23,
    parameter int WIDTH   = 1 + EXP + MANT,
    parameter int CVT_LAT = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     clock_sreset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*(MANT+1)-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [MANT:0]            cvt_data,
    output logic                     cvt_valid,
    input  logic [WIDTH-1:0]         cvt_result,
    input  logic                     cvt_result_valid,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_valid,
    input  logic                     drain_req,
    output logic                     drained,
    output logic                     tag_error
);

    localparam int DW   = MANT + 1;
    localparam int CNTW = $clog2(CVT_LAT + 3) + 1;
    localparam int LAST = CVT_LAT;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t            state_r;
    logic [IDW-1:0]    ptr_r;
    logic [NREQ-1:0]   grant_s;
    logic              grant_any_s;
    logic [IDW-1:0]    grant_id_s;
    logic [DW-1:0]     grant_data_s;
    logic [IDW:0]      idx_s;
    logic [CVT_LAT:0]  tag_vld_r;
    logic [IDW-1:0]    tag_id_r [CVT_LAT+1];
    logic [CNTW-1:0]   inflight_r;
    logic              underflow_s;
    logic              mismatch_s;

    assign req_ready = grant_s;

    // Round-robin search starting at ptr_r; only RUN may grant.
    always_comb begin
        grant_s      = '0;
        grant_any_s  = 1'b0;
        grant_id_s   = '0;
        grant_data_s = '0;
        idx_s        = '0;
        if ((state_r == ST_RUN) && !clock_sreset) begin
            for (int i = 0; i < NREQ; i++) begin
                idx_s = {1'b0, ptr_r} + (IDW+1)'(i);
                if (idx_s >= (IDW+1)'(NREQ)) begin
                    idx_s = idx_s - (IDW+1)'(NREQ);
                end else begin
                    idx_s = idx_s;
                end
                if (!grant_any_s && req_valid[idx_s[IDW-1:0]]) begin
                    grant_any_s                = 1'b1;
                    grant_s[idx_s[IDW-1:0]]    = 1'b1;
                    grant_id_s                 = idx_s[IDW-1:0];
                    grant_data_s               = req_data[idx_s[IDW-1:0]*DW +: DW];
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Integrity: tag valid must track converter valid; a response needs something in flight.
    always_comb begin
        mismatch_s  = (cvt_result_valid != tag_vld_r[LAST]);
        underflow_s = rsp_valid && (inflight_r == '0);
    end

    // Pointer advance and converter issue register.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            ptr_r     <= '0;
            cvt_valid <= 1'b0;
            cvt_data  <= '0;
        end else begin
            cvt_valid <= grant_any_s;
            if (grant_any_s) begin
                cvt_data <= grant_data_s;
                if (grant_id_s == IDW'(NREQ - 1)) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= grant_id_s + IDW'(1);
                end
            end
        end
    end

    // Tag pipeline; stage LAST lines up with cvt_result_valid.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            tag_vld_r <= '0;
            for (int i = 0; i <= CVT_LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_vld_r   <= {tag_vld_r[CVT_LAT-1:0], grant_any_s};
            tag_id_r[0] <= grant_id_s;
            for (int i = 1; i <= CVT_LAT; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Response register, inflight counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            inflight_r <= '0;
            tag_error  <= 1'b0;
        end else begin
            rsp_valid <= cvt_result_valid;
            if (cvt_result_valid) begin
                rsp_result <= cvt_result;
                rsp_id     <= tag_id_r[LAST];
            end
            case ({grant_any_s, rsp_valid})
                2'b10: begin
                    if (inflight_r != {CNTW{1'b1}}) begin
                        inflight_r <= inflight_r + CNTW'(1);
                    end
                end
                2'b01: begin
                    if (inflight_r != '0) begin
                        inflight_r <= inflight_r - CNTW'(1);
                    end
                end
                default: inflight_r <= inflight_r;
            endcase
            if (mismatch_s || underflow_s) begin
                tag_error <= 1'b1;
            end
        end
    end

    // Drain state machine; drained is registered alongside the state.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            state_r <= ST_RUN;
            drained <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    drained <= 1'b0;
                    if (drain_req) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req) begin
                        state_r <= ST_RUN;
                        drained <= 1'b0;
                    end else if ((inflight_r == '0) && !rsp_valid) begin
                        state_r <= ST_DRAINED;
                        drained <= 1'b1;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req) begin
                        state_r <= ST_RUN;
                        drained <= 1'b0;
                    end else begin
                        drained <= (inflight_r == '0);
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_i2f_arbiter.sv
// Directed bench for fp_i2f_arbiter with a 2-cycle converter model alongside.
module tb_fp_i2f_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 24;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic                 clock = 1'b0;
    logic                 clock_sreset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        cvt_data;
    logic                 cvt_valid;
    logic [W-1:0]         cvt_result;
    logic                 cvt_result_valid;
    logic [W-1:0]         rsp_result;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_valid;
    logic                 drain_req;
    logic                 drained;
    logic                 tag_error;

    logic                 force_rv;
    logic                 cv1, cv2;
    logic [W-1:0]         cd1, cd2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [23:0] op;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [8];

    always #5 clock = ~clock;

    fp_i2f_arbiter dut (
        .clock            (clock),
        .clock_sreset     (clock_sreset),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .cvt_data         (cvt_data),
        .cvt_valid        (cvt_valid),
        .cvt_result       (cvt_result),
        .cvt_result_valid (cvt_result_valid),
        .rsp_result       (rsp_result),
        .rsp_id           (rsp_id),
        .rsp_valid        (rsp_valid),
        .drain_req        (drain_req),
        .drained          (drained),
        .tag_error        (tag_error)
    );

    function automatic logic [31:0] i2f(input logic [23:0] v);
        logic        s;
        logic [23:0] m;
        logic [23:0] sh;
        int          p;
        logic [31:0] r;
        s = v[23];
        m = s ? (~v + 24'd1) : v;
        if (m == 24'd0) return 32'd0;
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        sh = m << (23 - p);
        r  = {s, 8'(127 + p), sh[22:0]};
        return r;
    endfunction

    always @(posedge clock) begin
        if (clock_sreset) begin
            cv1 <= 1'b0; cv2 <= 1'b0; cd1 <= 32'd0; cd2 <= 32'd0;
        end else begin
            cv1 <= cvt_valid; cd1 <= i2f(cvt_data);
            cv2 <= cv1;       cd2 <= cd1;
        end
    end
    assign cvt_result_valid = cv2 | force_rv;
    assign cvt_result       = cd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int k, input logic [23:0] v);
        req_data[k*DW +: DW] = v;
    endtask

    task automatic set_all_ops();
        for (int k = 0; k < NREQ; k++) set_op(k, 24'(k + 1));
    endtask

    task automatic do_reset();
        clock_sreset = 1'b1;
        req_valid    = 4'b0000;
        nxt();
        clock_sreset = 1'b0;
    endtask

    initial begin
        logic [31:0] rr_exp [4];
        rr_exp[0] = 32'h3F800000; rr_exp[1] = 32'h40000000;
        rr_exp[2] = 32'h40400000; rr_exp[3] = 32'h40800000;

        vt[0] = '{2, 24'd5,       32'h40A00000};
        vt[1] = '{1, 24'd1,       32'h3F800000};
        vt[2] = '{3, 24'd100,     32'h42C80000};
        vt[3] = '{0, 24'd8388607, 32'h4AFFFFFE};
        vt[4] = '{2, 24'h800000,  32'hCB000000};
        vt[5] = '{1, 24'hFFFFFE,  32'hC0000000};
        vt[6] = '{3, 24'd3,       32'h40400000};
        vt[7] = '{0, 24'd0,       32'h00000000};

        clock_sreset = 1'b1;
        req_valid    = 4'b0000;
        req_data     = '0;
        drain_req    = 1'b0;
        force_rv     = 1'b0;
        nxt();
        nxt();
        clock_sreset = 1'b0;
        #1;
        chk("rst_ready",     32'(req_ready),  32'd0);
        chk("rst_cvt_valid", 32'(cvt_valid),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_rsp_result", rsp_result,     32'd0);
        chk("rst_rsp_id",    32'(rsp_id),     32'd0);
        chk("rst_drained",   32'(drained),    32'd0);
        chk("rst_tag_error", 32'(tag_error),  32'd0);

        // Isolated transactions from the table.
        for (int t = 0; t < 8; t++) begin
            logic [3:0] oh;
            oh = 4'b0001 << vt[t].id;
            req_valid = oh;
            set_op(vt[t].id, vt[t].op);
            #1;
            chk($sformatf("vec%0d_grant", t), 32'(req_ready), 32'(oh));
            nxt();
            req_valid = 4'b0000;
            #1;
            chk($sformatf("vec%0d_ready_drop", t), 32'(req_ready), 32'd0);
            nxt();
            nxt();
            chk($sformatf("vec%0d_early", t), 32'(rsp_valid), 32'd0);
            nxt();
            chk($sformatf("vec%0d_rsp_valid", t), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_rsp_id", t), 32'(rsp_id), 32'(vt[t].id));
            chk($sformatf("vec%0d_rsp_result", t), rsp_result, vt[t].exp);
            nxt();
            chk($sformatf("vec%0d_pulse", t), 32'(rsp_valid), 32'd0);
        end

        // Requester 0 sends -1 then 0 back to back.
        req_valid = 4'b0001; set_op(0, 24'hFFFFFF); #1;
        chk("sz_grant0", 32'(req_ready), 32'h1);
        nxt();
        set_op(0, 24'd0); #1;
        chk("sz_grant1", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0000;
        nxt(); nxt();
        chk("sz_rsp0_valid", 32'(rsp_valid), 32'd1);
        chk("sz_rsp0_id", 32'(rsp_id), 32'd0);
        chk("sz_rsp0_result", rsp_result, 32'hBF800000);
        nxt();
        chk("sz_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("sz_rsp1_id", 32'(rsp_id), 32'd0);
        chk("sz_rsp1_result", rsp_result, 32'h00000000);

        // Round robin from ptr=0 with all requesters valid for 8 cycles.
        do_reset();
        set_all_ops();
        for (int i = 0; i < 13; i++) begin
            req_valid = (i < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("rr%0d_grant", i), 32'(req_ready),
                (i < 8) ? 32'(4'b0001 << (i % 4)) : 32'd0);
            if (i >= 4 && i < 12) begin
                chk($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
                chk($sformatf("rr%0d_rsp_id", i), 32'(rsp_id), 32'((i - 4) % 4));
                chk($sformatf("rr%0d_rsp_result", i), rsp_result, rr_exp[(i - 4) % 4]);
            end else begin
                chk($sformatf("rr%0d_rsp_idle", i), 32'(rsp_valid), 32'd0);
            end
            nxt();
        end

        // Drain raised on the third grant; requester 1 then waits.
        req_valid = 4'b0001; set_op(0, 24'd7); #1;
        chk("dr_g0", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0010; set_op(1, 24'd8); #1;
        chk("dr_g1", 32'(req_ready), 32'h2);
        nxt();
        req_valid = 4'b0100; set_op(2, 24'd9); drain_req = 1'b1; #1;
        chk("dr_g2", 32'(req_ready), 32'h4);
        nxt();
        req_valid = 4'b0010; set_op(1, 24'd6);
        for (int d = 3; d <= 9; d++) begin
            if (d == 9) drain_req = 1'b0;
            #1;
            chk($sformatf("dr%0d_blocked", d), 32'(req_ready), 32'd0);
            if (d >= 4 && d <= 6) begin
                chk($sformatf("dr%0d_rsp_valid", d), 32'(rsp_valid), 32'd1);
                chk($sformatf("dr%0d_rsp_id", d), 32'(rsp_id), 32'(d - 4));
                chk($sformatf("dr%0d_rsp_result", d), rsp_result,
                    (d == 4) ? 32'h40E00000 : ((d == 5) ? 32'h41000000 : 32'h41100000));
            end
            chk($sformatf("dr%0d_drained", d), 32'(drained), (d >= 8) ? 32'd1 : 32'd0);
            nxt();
        end
        #1;
        chk("dr10_regrant", 32'(req_ready), 32'h2);
        chk("dr10_drained", 32'(drained), 32'd0);
        nxt();
        req_valid = 4'b0000;
        nxt(); nxt(); nxt();
        chk("dr14_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("dr14_rsp_id", 32'(rsp_id), 32'd1);
        chk("dr14_rsp_result", rsp_result, 32'h40C00000);

        // Reset while two conversions are in flight.
        nxt();
        req_valid = 4'b0001; set_op(0, 24'd5); #1;
        chk("mr_g0", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0010; set_op(1, 24'd9); #1;
        chk("mr_g1", 32'(req_ready), 32'h2);
        nxt();
        do_reset();
        #1;
        chk("mr_cvt_valid", 32'(cvt_valid), 32'd0);
        chk("mr_rsp_result", rsp_result, 32'd0);
        chk("mr_rsp_id", 32'(rsp_id), 32'd0);
        chk("mr_drained", 32'(drained), 32'd0);
        chk("mr_tag_error", 32'(tag_error), 32'd0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("mr%0d_no_rsp", j), 32'(rsp_valid), 32'd0);
            nxt();
        end
        drain_req = 1'b1;
        nxt(); nxt();
        chk("mr_drained_fast", 32'(drained), 32'd1);
        drain_req = 1'b0;
        nxt();
        set_all_ops();
        req_valid = 4'b1111; #1;
        chk("mr_ptr_zero", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0000;
        nxt(); nxt(); nxt();
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mr_rsp_result", rsp_result, 32'h3F800000);
        chk("mr_tag_ok", 32'(tag_error), 32'd0);

        // Spurious converter valid with an empty tag pipeline.
        nxt(); nxt(); nxt();
        force_rv = 1'b1;
        nxt();
        force_rv = 1'b0;
        chk("err_set", 32'(tag_error), 32'd1);
        nxt(); nxt(); nxt(); nxt();
        chk("err_sticky", 32'(tag_error), 32'd1);
        do_reset();
        chk("err_cleared", 32'(tag_error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
